// File: rtl/gimbal_ctrl.sv
// gimbal_ctrl: altitude-hysteresis gimbal engage control with a bit-serial restoring divider for ang_vel.
// Optional build macro GIMBAL_RATE_LIMIT_EN slew-limits each ang_vel update to MAX_STEP.
module gimbal_ctrl #(
    parameter int unsigned  W        = 64,
    parameter logic [W-1:0] ALT_ON   = W'(30_000),
    parameter logic [W-1:0] ALT_OFF  = W'(29_000),
    parameter logic [W-1:0] RADIUS   = W'(400_000),
    parameter logic [W-1:0] MAX_STEP = W'(1)
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         sample_valid,
    output logic         sample_ready,
    input  logic [W-1:0] velocity,
    input  logic [W-1:0] height,
    output logic         gimbal_enable,
    output logic [W-1:0] ang_vel,
    output logic         ang_vel_valid,
    output logic [W-1:0] entry_altitude,
    output logic [W-1:0] noair_distance
);

    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        COAST,
        ENGAGED,
        DIVIDE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dq;
    logic [W-1:0]  rem;
    logic [W:0]    rem_sh;
    logic [W-1:0]  rem_sub;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  dq_nxt;
    logic          qbit;
    logic [W-1:0]  ang_upd;
    logic          do_engage;
    logic          do_disengage;
    logic          do_accum;
    logic          div_done;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

`ifdef GIMBAL_RATE_LIMIT_EN
    function automatic logic [W-1:0] slew(input logic [W-1:0] prev, input logic [W-1:0] tgt);
        if (tgt > prev)
            return ((tgt - prev) > MAX_STEP) ? prev + MAX_STEP : tgt;
        return ((prev - tgt) > MAX_STEP) ? prev - MAX_STEP : tgt;
    endfunction
`endif

    // dq holds the dividend and fills with quotient bits from the LSB as dividend bits shift out the top
    always_comb begin
        rem_sh  = {rem, dq[W-1]};
        qbit    = (rem_sh >= {1'b0, RADIUS});
        rem_sub = rem_sh[W-1:0] - RADIUS;
        rem_nxt = qbit ? rem_sub : rem_sh[W-1:0];
        dq_nxt  = {dq[W-2:0], qbit};
    end

    always_comb begin
`ifdef GIMBAL_RATE_LIMIT_EN
        ang_upd = slew(ang_vel, dq_nxt);
`else
        ang_upd = dq_nxt;
`endif
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb)
            state <= COAST;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b1;
        do_engage    = 1'b0;
        do_disengage = 1'b0;
        do_accum     = 1'b0;
        div_done     = 1'b0;
        unique case (state)
            COAST: begin
                if (sample_valid && (height > ALT_ON)) begin
                    do_engage = 1'b1;
                    state_nxt = DIVIDE;
                end
            end
            ENGAGED: begin
                if (sample_valid) begin
                    if (height < ALT_OFF) begin
                        do_disengage = 1'b1;
                        state_nxt    = COAST;
                    end else begin
                        do_accum  = 1'b1;
                        state_nxt = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                sample_ready = 1'b0;
                if (cnt == CW'(1)) begin
                    div_done  = 1'b1;
                    state_nxt = ENGAGED;
                end
            end
            default: state_nxt = COAST;
        endcase
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            gimbal_enable  <= 1'b0;
            ang_vel        <= '0;
            ang_vel_valid  <= 1'b0;
            entry_altitude <= '0;
            noair_distance <= '0;
            dq             <= '0;
            rem            <= '0;
            cnt            <= '0;
        end else begin
            ang_vel_valid <= 1'b0;
            if (do_engage) begin
                gimbal_enable  <= 1'b1;
                entry_altitude <= height;
                noair_distance <= '0;
            end
            if (do_accum)
                noair_distance <= sat_add(noair_distance, velocity);
            if (do_engage || do_accum) begin
                dq  <= velocity;
                rem <= '0;
                cnt <= CW'(W);
            end else if (state == DIVIDE) begin
                dq  <= dq_nxt;
                rem <= rem_nxt;
                cnt <= cnt - CW'(1);
            end
            if (div_done) begin
                ang_vel       <= ang_upd;
                ang_vel_valid <= 1'b1;
            end
            if (do_disengage) begin
                gimbal_enable <= 1'b0;
                ang_vel       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gimbal_ctrl.sv
// Bench for gimbal_ctrl: directed vector table, reset-during-divide sequence and randomized model check.
module tb_gimbal_ctrl;

    localparam int unsigned W        = 64;
    localparam logic [63:0] ALT_ON   = 64'd30_000;
    localparam logic [63:0] ALT_OFF  = 64'd29_000;
    localparam logic [63:0] RADIUS   = 64'd400_000;
    localparam logic [63:0] MAX_STEP = 64'd1;
    localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        resetb;
    logic        sample_valid;
    logic        sample_ready;
    logic [63:0] velocity;
    logic [63:0] height;
    logic        gimbal_enable;
    logic [63:0] ang_vel;
    logic        ang_vel_valid;
    logic [63:0] entry_altitude;
    logic [63:0] noair_distance;

    int total = 0;
    int bad   = 0;

    gimbal_ctrl #(
        .W(W), .ALT_ON(ALT_ON), .ALT_OFF(ALT_OFF), .RADIUS(RADIUS), .MAX_STEP(MAX_STEP)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .velocity(velocity),
        .height(height),
        .gimbal_enable(gimbal_enable),
        .ang_vel(ang_vel),
        .ang_vel_valid(ang_vel_valid),
        .entry_altitude(entry_altitude),
        .noair_distance(noair_distance)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] h;
        logic [63:0] v;
        bit          div;
        logic        en;
        logic [63:0] ang;
        logic [63:0] entry;
        logic [63:0] noair;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic        m_eng;
    logic [63:0] m_ang;
    logic [63:0] m_entry;
    logic [63:0] m_noair;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] limit(input logic [63:0] prev, input logic [63:0] q);
`ifdef GIMBAL_RATE_LIMIT_EN
        if (q > prev) return (q - prev > MAX_STEP) ? prev + MAX_STEP : q;
        return (prev - q > MAX_STEP) ? prev - MAX_STEP : q;
`else
        return (prev === 64'hx) ? q : q;
`endif
    endfunction

    task automatic model_reset();
        m_eng = 1'b0; m_ang = '0; m_entry = '0; m_noair = '0;
    endtask

    task automatic model_step(input logic [63:0] h, input logic [63:0] v, output bit div);
        div = 1'b0;
        if (!m_eng) begin
            if (h > ALT_ON) begin
                m_eng = 1'b1; m_entry = h; m_noair = '0;
                m_ang = limit(m_ang, v / RADIUS);
                div = 1'b1;
            end
        end else if (h < ALT_OFF) begin
            m_eng = 1'b0; m_ang = '0;
        end else begin
            m_noair = (v > ALL1 - m_noair) ? ALL1 : m_noair + v;
            m_ang = limit(m_ang, v / RADIUS);
            div = 1'b1;
        end
    endtask

    task automatic run_txn(input string tag, input logic [63:0] h, input logic [63:0] v, input bit exp_div,
                           input logic exp_en, input logic [63:0] exp_ang,
                           input logic [63:0] exp_entry, input logic [63:0] exp_noair);
        int lat;
        int rdy_lo;
        int pulses;
        @(negedge clk);
        chk({tag, ".ready_idle"}, 64'(sample_ready), 64'd1);
        sample_valid = 1'b1; height = h; velocity = v;
        @(negedge clk);
        chk({tag, ".enable"}, 64'(gimbal_enable), 64'(exp_en));
        if (exp_div) begin
            lat = 0; rdy_lo = 0;
            while (!ang_vel_valid && lat < 200) begin
                if (!sample_ready) rdy_lo++;
                sample_valid = 1'b1;
                height = {$urandom, $urandom};
                velocity = {$urandom, $urandom};
                @(negedge clk);
                lat++;
            end
            sample_valid = 1'b0;
            chk({tag, ".latency"}, 64'(lat), 64'd64);
            chk({tag, ".ready_low_cycles"}, 64'(rdy_lo), 64'd64);
            chk({tag, ".ang_vel"}, ang_vel, exp_ang);
            @(negedge clk);
            chk({tag, ".pulse_width"}, 64'(ang_vel_valid), 64'd0);
        end else begin
            sample_valid = 1'b0;
            pulses = 0;
            repeat (4) begin
                if (ang_vel_valid) pulses++;
                @(negedge clk);
            end
            chk({tag, ".no_pulse"}, 64'(pulses), 64'd0);
            chk({tag, ".ang_vel"}, ang_vel, exp_ang);
        end
        chk({tag, ".ready_after"}, 64'(sample_ready), 64'd1);
        chk({tag, ".enable_after"}, 64'(gimbal_enable), 64'(exp_en));
        chk({tag, ".entry"}, entry_altitude, exp_entry);
        chk({tag, ".noair"}, noair_distance, exp_noair);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          d;
        int          pulses;
        logic [63:0] h;
        logic [63:0] v;

        resetb = 1'b1; sample_valid = 1'b0; height = '0; velocity = '0;
        repeat (3) @(negedge clk);
        chk("rst.enable", 64'(gimbal_enable), 64'd0);
        chk("rst.ang_vel", ang_vel, 64'd0);
        chk("rst.valid", 64'(ang_vel_valid), 64'd0);
        chk("rst.entry", entry_altitude, 64'd0);
        chk("rst.noair", noair_distance, 64'd0);
        resetb = 1'b0;
        @(negedge clk);
        chk("rst.ready", 64'(sample_ready), 64'd1);

`ifdef GIMBAL_RATE_LIMIT_EN
        tbl.push_back(vec_t'{64'd20_000, 64'd800_000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0});
        tbl.push_back(vec_t'{64'd30_001, 64'd2_000_000, 1'b1, 1'b1, 64'd1, 64'd30_001, 64'd0});
        tbl.push_back(vec_t'{64'd30_001, 64'd2_000_000, 1'b1, 1'b1, 64'd2, 64'd30_001, 64'd2_000_000});
        tbl.push_back(vec_t'{64'd30_001, 64'd0, 1'b1, 1'b1, 64'd1, 64'd30_001, 64'd2_000_000});
        tbl.push_back(vec_t'{64'd28_999, 64'd0, 1'b0, 1'b0, 64'd0, 64'd30_001, 64'd2_000_000});
`else
        tbl.push_back(vec_t'{64'd20_000, 64'd800_000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0});
        tbl.push_back(vec_t'{64'd30_000, 64'd800_000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0});
        tbl.push_back(vec_t'{64'd30_001, 64'd800_000, 1'b1, 1'b1, 64'd2, 64'd30_001, 64'd0});
        tbl.push_back(vec_t'{64'd29_500, 64'd1_200_000, 1'b1, 1'b1, 64'd3, 64'd30_001, 64'd1_200_000});
        tbl.push_back(vec_t'{64'd29_000, 64'd400_000, 1'b1, 1'b1, 64'd1, 64'd30_001, 64'd1_600_000});
        tbl.push_back(vec_t'{64'd28_999, 64'd5, 1'b0, 1'b0, 64'd0, 64'd30_001, 64'd1_600_000});
        tbl.push_back(vec_t'{64'd50_000, 64'd399_999, 1'b1, 1'b1, 64'd0, 64'd50_000, 64'd0});
        tbl.push_back(vec_t'{64'd60_000, ALL1, 1'b1, 1'b1, 64'd46_116_860_184_273, 64'd50_000, ALL1});
        tbl.push_back(vec_t'{64'd60_000, 64'd10, 1'b1, 1'b1, 64'd0, 64'd50_000, ALL1});
        tbl.push_back(vec_t'{64'd0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd50_000, ALL1});
`endif
        for (int i = 0; i < tbl.size(); i++)
            run_txn($sformatf("vec%0d", i), tbl[i].h, tbl[i].v, tbl[i].div, tbl[i].en,
                    tbl[i].ang, tbl[i].entry, tbl[i].noair);

        // reset ten cycles into a division
        @(negedge clk);
        sample_valid = 1'b1; height = 64'd40_000; velocity = 64'd800_000;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("rdiv.busy", 64'(sample_ready), 64'd0);
        #2 resetb = 1'b1;
        #1;
        chk("rdiv.enable", 64'(gimbal_enable), 64'd0);
        chk("rdiv.ang_vel", ang_vel, 64'd0);
        chk("rdiv.valid", 64'(ang_vel_valid), 64'd0);
        chk("rdiv.entry", entry_altitude, 64'd0);
        chk("rdiv.noair", noair_distance, 64'd0);
        @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        chk("rdiv.ready_release", 64'(sample_ready), 64'd1);
        pulses = 0;
        repeat (70) begin
            if (ang_vel_valid) pulses++;
            @(negedge clk);
        end
        chk("rdiv.no_pulse", 64'(pulses), 64'd0);

        model_reset();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: h = ALT_ON;
                1: h = ALT_OFF;
                2: h = ALT_ON + 64'd1;
                3: h = ALT_OFF - 64'd1;
                default: h = 64'($urandom_range(0, 60_000));
            endcase
            if ($urandom_range(0, 3) == 0) v = {$urandom, $urandom};
            else v = 64'($urandom_range(0, 3_000_000));
            model_step(h, v, d);
            run_txn($sformatf("rnd%0d", n), h, v, d, m_eng, m_ang, m_entry, m_noair);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
